// File: rtl/instr_fetch_unit.sv
// Byte-serial fetch: four acked bytes (LSB first) form one instruction; valid 4 cycles after FETCH with ack high.
// Stalls indefinitely on low mem_ack; holds the instruction until instr_ready; redirect overrides all but reset.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = 8'h00,
  parameter int                 CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t            r_state;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic              r_misalign_err;
  logic [CNT_W-1:0]  r_retired_cnt;
  logic              w_handshake;
  logic [ADDR_W-1:0] w_pc_plus4;

  assign w_handshake = r_instr_valid && instr_ready;
  assign w_pc_plus4  = r_pc + ADDR_W'(4);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_FETCH;
      r_byte_idx     <= 2'd0;
      r_pc           <= RESET_PC;
      r_fetch_addr   <= RESET_PC;
      r_instr        <= 32'd0;
      r_instr_valid  <= 1'b0;
      r_misalign_err <= 1'b0;
      r_retired_cnt  <= '0;
    end else begin
      if (redirect && (redirect_pc[1:0] != 2'b00))
        r_misalign_err <= 1'b1;
      // A handshake retires even when a redirect wins the PC update in the same cycle
      if (w_handshake && (r_retired_cnt != {CNT_W{1'b1}}))
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);

      if (redirect) begin
        r_pc          <= redirect_pc;
        r_fetch_addr  <= redirect_pc;
        r_byte_idx    <= 2'd0;
        r_state       <= S_FETCH;
        r_instr_valid <= 1'b0;
      end else begin
        case (r_state)
          S_FETCH: begin
            if (mem_ack) begin
              r_instr[{r_byte_idx, 3'b000} +: 8] <= mem_rdata;
              r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
              r_byte_idx   <= r_byte_idx + 2'd1;
              if (r_byte_idx == 2'd3) begin
                r_state       <= S_HOLD;
                r_instr_valid <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (w_handshake) begin
              r_pc          <= w_pc_plus4;
              r_byte_idx    <= 2'd0;
              r_state       <= S_FETCH;
              r_instr_valid <= 1'b0;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  assign mem_req      = (r_state == S_FETCH) && !reset;
  assign mem_addr     = r_fetch_addr;
  assign instr        = r_instr;
  assign op           = r_instr[31:26];
  assign rs           = r_instr[25:21];
  assign rt           = r_instr[20:16];
  assign rd           = r_instr[15:11];
  assign imm          = r_instr[15:0];
  assign funct        = r_instr[5:0];
  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign instr_valid  = r_instr_valid;
  assign misalign_err = r_misalign_err;
  assign retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; byte memory modelled as a flat array read combinationally.
module tb_instr_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [7:0]  pc, pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        misalign_err;
  logic [15:0] retired_cnt;

  logic [7:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clock = ~clock;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .op(op),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .pc(pc),
    .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .misalign_err(misalign_err),
    .retired_cnt(retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic fetch4();
    mem_ack = 1'b1;
    repeat (4) cyc();
    mem_ack = 1'b0;
  endtask

  task automatic handshake();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[0] = 8'h20; mem[1] = 8'h10; mem[2] = 8'h22; mem[3] = 8'h00;
    mem[4] = 8'h20; mem[5] = 8'h10; mem[6] = 8'h22; mem[7] = 8'h00;
    mem[8'h0A] = 8'hEE;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'hFC] = 8'h78; mem[8'hFD] = 8'h56; mem[8'hFE] = 8'h34; mem[8'hFF] = 8'h12;

    reset = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    repeat (2) cyc();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_instr", instr, 32'h0);

    // Basic fetch with ack tied high
    reset = 1'b0; mem_ack = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 32'(mem_addr), 32'(i));
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_valid_lo", 32'(instr_valid), 32'd0);
      cyc();
    end
    mem_ack = 1'b0;
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h00221020);
    chk("t1_op", 32'(op), 32'h0);
    chk("t1_funct", 32'(funct), 32'h20);
    chk("t1_rs", 32'(rs), 32'd1);
    chk("t1_rt", 32'(rt), 32'd2);
    chk("t1_rd", 32'(rd), 32'd2);
    chk("t1_imm", 32'(imm), 32'h1020);
    chk("t1_req_hold", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    repeat (2) cyc();
    mem_ack = 1'b0;
    chk("t1_hold_valid", 32'(instr_valid), 32'd1);
    chk("t1_hold_instr", instr, 32'h00221020);
    chk("t1_cnt_wait", 32'(retired_cnt), 32'd0);
    handshake();
    chk("t1_valid_drop", 32'(instr_valid), 32'd0);
    chk("t1_cnt", 32'(retired_cnt), 32'd1);
    chk("t1_pc", 32'(pc), 32'h04);
    chk("t1_pc4", 32'(pc_plus4), 32'h08);
    chk("t1_next_addr", 32'(mem_addr), 32'h04);
    chk("t1_next_req", 32'(mem_req), 32'd1);

    // Ack only every third cycle
    for (int k = 0; k < 12; k++) begin
      mem_ack = ((k % 3) == 2);
      #1;
      chk("t2_addr", 32'(mem_addr), 32'(4 + k / 3));
      chk("t2_valid_lo", 32'(instr_valid), 32'd0);
      cyc();
    end
    mem_ack = 1'b0;
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_instr", instr, 32'h00221020);
    handshake();
    chk("t2_cnt", 32'(retired_cnt), 32'd2);
    chk("t2_pc", 32'(pc), 32'h08);

    // Redirect while byte 2 is being acked
    mem_ack = 1'b1;
    repeat (2) cyc();
    redirect = 1'b1; redirect_pc = 8'h10;
    cyc();
    redirect = 1'b0;
    chk("t3_addr", 32'(mem_addr), 32'h10);
    chk("t3_pc", 32'(pc), 32'h10);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_misalign", 32'(misalign_err), 32'd0);
    fetch4();
    chk("t3_instr", instr, 32'h44332211);
    chk("t3_valid_up", 32'(instr_valid), 32'd1);

    // Unaligned redirect sets the sticky error
    redirect = 1'b1; redirect_pc = 8'h0E;
    cyc();
    redirect = 1'b0;
    chk("t4_misalign", 32'(misalign_err), 32'd1);
    chk("t4_addr", 32'(mem_addr), 32'h0E);
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_cnt", 32'(retired_cnt), 32'd2);
    redirect = 1'b1; redirect_pc = 8'h20;
    cyc();
    redirect = 1'b0;
    chk("t4_sticky", 32'(misalign_err), 32'd1);
    chk("t4_addr2", 32'(mem_addr), 32'h20);
    fetch4();
    chk("t4_valid_up", 32'(instr_valid), 32'd1);
    // Redirect and handshake together: counted, redirect target wins
    redirect = 1'b1; redirect_pc = 8'hFC; instr_ready = 1'b1;
    cyc();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("t4_rh_cnt", 32'(retired_cnt), 32'd3);
    chk("t4_rh_pc", 32'(pc), 32'hFC);
    chk("t4_rh_addr", 32'(mem_addr), 32'hFC);
    chk("t4_pc4_wrap", 32'(pc_plus4), 32'h00);

    // Fetch across the top of the address space
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_addr", 32'(mem_addr), 32'(8'(8'hFC + i)));
      cyc();
    end
    mem_ack = 1'b0;
    chk("t5_instr", instr, 32'h12345678);
    handshake();
    chk("t5_pc", 32'(pc), 32'h00);
    chk("t5_addr_wrap", 32'(mem_addr), 32'h00);
    chk("t5_cnt", 32'(retired_cnt), 32'd4);

    // Retired counter saturation
    fetch4();
    chk("t6_instr", instr, 32'h00221020);
    force dut.r_retired_cnt = 16'hFFFF;
    #1;
    release dut.r_retired_cnt;
    handshake();
    chk("t6_sat", 32'(retired_cnt), 32'hFFFF);
    chk("t6_pc", 32'(pc), 32'h04);

    // Reset during HOLD overrides a simultaneous redirect
    fetch4();
    chk("t7_valid_up", 32'(instr_valid), 32'd1);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    cyc();
    chk("t7_valid", 32'(instr_valid), 32'd0);
    chk("t7_pc", 32'(pc), 32'h00);
    chk("t7_cnt", 32'(retired_cnt), 32'd0);
    chk("t7_misalign", 32'(misalign_err), 32'd0);
    chk("t7_instr", instr, 32'h0);
    chk("t7_req", 32'(mem_req), 32'd0);
    reset = 1'b0; redirect = 1'b0;
    #1;
    chk("t7_req_after", 32'(mem_req), 32'd1);
    chk("t7_addr_after", 32'(mem_addr), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Byte-serial instruction fetch stage sitting directly upstream of the multicycle control unit.
- Reads four consecutive bytes from the 8-bit instruction memory over a req/ack handshake and assembles them into a 32-bit instruction, least-significant byte first.
- Presents the decoded fields (op, funct, rs, rt, rd, imm) with a valid/ready handshake.
- Accepts PC redirects for taken branches and jumps.

Parameters:
- ADDR_W, 8, width of byte address / PC.
- RESET_PC, 8'h00, PC loaded on reset.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  byte read request
- mem_addr  out  ADDR_W  byte address of current request
- mem_ack  in  1  memory returns mem_rdata this cycle
- mem_rdata  in  8  read byte
- instr  out  32  assembled instruction
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- imm  out  16  instr[15:0]
- pc  out  ADDR_W  address of byte 0 of the current instruction
- pc_plus4  out  ADDR_W  pc+4, modulo 2^ADDR_W
- instr_valid  out  1  instr stable and complete
- instr_ready  in  1  consumer takes instruction
- redirect  in  1  load new PC (taken beq / j)
- redirect_pc  in  ADDR_W  target address
- misalign_err  out  1  sticky; a redirect target had redirect_pc[1:0]!=0
- retired_cnt  out  CNT_W  count of handshaken instructions, saturating

Behaviour:
- Reset (synchronous, active-high), synchronous to clock:
  - state=FETCH, byte_idx=0, pc=RESET_PC, fetch_addr=RESET_PC.
  - instr=0, instr_valid=0, misalign_err=0, retired_cnt=0.
  - Reset overrides redirect and every other input.
- States: FETCH, HOLD.
- FETCH:
  - mem_req=1 (combinational, = state==FETCH and not reset); mem_addr=fetch_addr.
  - On a cycle with mem_ack=1, at the next edge:
    - instr[8*byte_idx+:8] <= mem_rdata.
    - fetch_addr <= fetch_addr+1.
    - byte_idx <= byte_idx+1.
  - Accepting byte_idx=3 moves the FSM to HOLD and sets instr_valid=1 at the same edge.
  - mem_ack low: wait indefinitely, no state change; mem_ack is ignored outside FETCH.
- Latency: with mem_ack tied high, instr_valid rises 4 cycles after entering FETCH.
- HOLD:
  - mem_req=0; instr and fields held stable.
  - When instr_valid && instr_ready, at the next edge:
    - pc <= pc_plus4; fetch_addr already equals pc_plus4.
    - byte_idx <= 0, state <= FETCH, instr_valid <= 0.
    - retired_cnt increments, saturating at all-ones.
  - No back-to-back valid: there is at least one FETCH cycle between instructions.
- Redirect has priority over everything except reset, in any state. At the next edge:
  - pc <= redirect_pc, fetch_addr <= redirect_pc, byte_idx <= 0, state <= FETCH, instr_valid <= 0.
  - Partially assembled bytes are discarded, including a byte acked in the same cycle.
- Redirect together with instr_valid && instr_ready in the same cycle: the instruction counts as retired (retired_cnt increments) and the redirect target is used, not pc_plus4.
- misalign_err is set when redirect=1 and redirect_pc[1:0]!=0; it is cleared only by reset. The fetch still proceeds from the unaligned address.
- Address arithmetic is modulo 2^ADDR_W: fetch_addr 8'hFF+1 -> 8'h00, pc_plus4 of 8'hFC -> 8'h00.
- Field outputs are pure slices of the instr register; no decode logic.
- instr is not cleared when a new fetch starts. Consumers must qualify it with instr_valid.

Test Plan:
- Reset, mem_ack=1, memory bytes at 0..3 = 20,10,22,00 -> mem_addr walks 0,1,2,3 while mem_req=1; instr=32'h00221020 with instr_valid=1 from cycle 4 after reset release; op=0, funct=6'h20, rd=2; retired_cnt=0 until instr_ready=1, then retired_cnt=1, pc=4.
- Same bytes with mem_ack asserted only every third cycle -> identical instr; instr_valid rises 12 cycles after fetch start; mem_addr held constant during each wait.
- redirect=1, redirect_pc=8'h10 asserted while byte_idx=2 and mem_ack=1 -> acked byte dropped; next mem_addr=8'h10; the instruction assembled is from bytes 0x10..0x13; misalign_err stays 0.
- redirect_pc=8'h0E -> misalign_err=1, persists after further aligned redirects, clears only on reset.
- pc=8'hFC, instruction at FC..FF handshaken -> pc=8'h00 and fetch wraps to mem_addr 8'h00.
- retired_cnt preloaded to 16'hFFFF (force) plus one handshake -> stays 16'hFFFF. Also: reset asserted during HOLD -> instr_valid=0 and pc=RESET_PC next cycle.
